ibufg_bus_if: RTL and testbench

- Synchronous bottom-half host-bus front end for the TOP2049 FPGA.
- Buffers the host bus inputs. ALE goes through an IBUFG; OSC, READ and WRITE go through IBUFs.
- Latches the bus address and decodes write and read cycles into single-cycle strobes for payload logic.
- Serves the runtime-ID bytes, and provides the µs delay counter and command run/finish flags used by chip-specific bottom halves.

---
 rtl/bottomhalf_pkg.sv | 22 ++
 rtl/bus_edge_sync.sv | 37 +++
 rtl/xil_ibuf.sv | 20 ++
 rtl/ibufg_bus_if.sv | 187 ++++++++++++++++++
 tb/tb_ibufg_bus_if.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bottomhalf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bottomhalf_pkg
// Description : Shared constants and helpers for TOP2049 bottom-half logic.
// Revision    : 1.0 - initial release
// ============================================================================
package bottomhalf_pkg;

    localparam int unsigned ADDR_OK_BIT   = 4;
    localparam int unsigned UDELAY_MAX_US = 2730;

    localparam logic [7:0] ADDR_ID_MAJ_LO = 8'hFD;
    localparam logic [7:0] ADDR_ID_MAJ_HI = 8'hFE;
    localparam logic [7:0] ADDR_ID_MIN    = 8'hFF;

    // Payload register address: the base with the driver-enable bit set.
    function automatic logic [7:0] ADDR(input logic [7:0] base);
        return base | (8'h01 << ADDR_OK_BIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : bus_edge_sync
// Description : Two-flop synchronizer followed by a rise/fall edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
            prev_q  <= RST_VAL;
        end else begin
            sync1_q <= sig_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;
    assign fall_o = ~sync2_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/xil_ibuf.sv
`default_nettype none
// ============================================================================
// Module      : IBUF / IBUFG
// Description : Behavioural stand-ins for the vendor input-buffer primitives.
// Revision    : 1.0 - initial release
// ============================================================================
module IBUF (
    input  wire I,
    output wire O
);
    assign O = I;
endmodule

module IBUFG (
    input  wire I,
    output wire O
);
    assign O = I;
endmodule
`default_nettype wire

// File: rtl/ibufg_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : ibufg_bus_if
// Description : TOP2049 host-bus front end: address latch, strobes, runtime
//               ID readback, microsecond delay counter and command flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ibufg_bus_if
    import bottomhalf_pkg::*;
#(
    parameter logic [15:0] ID_MAJOR    = 16'h0000,
    parameter logic [7:0]  ID_MINOR    = 8'h00,
    parameter int unsigned ADDR_OK_BIT = bottomhalf_pkg::ADDR_OK_BIT,
    parameter int unsigned CLKS_PER_US = 24
) (
    input  logic        osc,
    input  logic        rst_n,
    input  logic        ale,
    input  logic        write,
    input  logic        read,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    output logic        data_oe,
    output logic        wr_stb,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        rd_stb,
    input  logic [7:0]  usr_rd_data,
    input  logic        udelay_load,
    input  logic [11:0] udelay_us,
    output logic        delay_idle,
    input  logic        cmd_run,
    input  logic [3:0]  cmd_nr_in,
    input  logic        cmd_finish,
    input  logic        cmd_state_set,
    input  logic [3:0]  cmd_state_in,
    output logic        cmd_running,
    output logic [3:0]  cmd_nr,
    output logic [3:0]  cmd_state
);

    logic osc_b, ale_b, read_b, write_b;

    IBUF  u_osc_buf   (.I(osc),   .O(osc_b));
    IBUFG u_ale_buf   (.I(ale),   .O(ale_b));
    IBUF  u_read_buf  (.I(read),  .O(read_b));
    IBUF  u_write_buf (.I(write), .O(write_b));

    logic ale_rise, ale_fall, wr_rise, wr_fall, rd_rise, rd_fall;

    bus_edge_sync #(.RST_VAL(1'b0)) u_ale_sync (
        .clk_i(osc_b), .rst_ni(rst_n), .sig_i(ale_b),
        .rise_o(ale_rise), .fall_o(ale_fall)
    );
    bus_edge_sync #(.RST_VAL(1'b0)) u_write_sync (
        .clk_i(osc_b), .rst_ni(rst_n), .sig_i(write_b),
        .rise_o(wr_rise), .fall_o(wr_fall)
    );
    // Read idles high, so its synchronizer resets high to avoid a bogus edge.
    bus_edge_sync #(.RST_VAL(1'b1)) u_read_sync (
        .clk_i(osc_b), .rst_ni(rst_n), .sig_i(read_b),
        .rise_o(rd_rise), .fall_o(rd_fall)
    );

    logic [7:0]  latch_q,    latch_d;
    logic [7:0]  pend_q,     pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        wr_stb_q,   wr_stb_d;
    logic [7:0]  wr_data_q,  wr_data_d;
    logic        rd_stb_q,   rd_stb_d;
    logic [7:0]  data_o_q,   data_o_d;
    logic [15:0] count_q,    count_d;
    logic        idle_q,     idle_d;
    logic        running_q,  running_d;
    logic [3:0]  nr_q,       nr_d;
    logic [3:0]  state_q,    state_d;

    logic [11:0] us_clamped;
    logic [15:0] load_val;

    always_comb begin
        us_clamped = (udelay_us > 12'(UDELAY_MAX_US)) ? 12'(UDELAY_MAX_US) : udelay_us;
        load_val   = (us_clamped == 12'd0) ? 16'd0
                   : 16'(32'(us_clamped) * 32'(CLKS_PER_US) - 32'd1);
    end

    always_comb begin
        latch_d    = latch_q;
        pend_d     = pend_q;
        pend_vld_d = 1'b0;
        // A strobe coinciding with an ALE edge must still see the old address,
        // so the new address is parked for one cycle.
        if (ale_fall) begin
            if (wr_rise || rd_fall) begin
                pend_d     = data_i;
                pend_vld_d = 1'b1;
            end else begin
                latch_d = data_i;
            end
        end else if (pend_vld_q) begin
            latch_d = pend_q;
        end

        wr_stb_d  = wr_rise;
        wr_data_d = wr_rise ? data_i : wr_data_q;
        rd_stb_d  = rd_fall;

        data_o_d = data_o_q;
        if (rd_stb_q) begin
            case (latch_q)
                ADDR_ID_MAJ_LO: data_o_d = ID_MAJOR[7:0];
                ADDR_ID_MAJ_HI: data_o_d = ID_MAJOR[15:8];
                ADDR_ID_MIN:    data_o_d = ID_MINOR;
                default:        data_o_d = usr_rd_data;
            endcase
        end

        count_d = count_q;
        if (udelay_load) begin
            count_d = load_val;
        end else if (count_q != 16'd0) begin
            count_d = count_q - 16'd1;
        end
        idle_d = (count_d == 16'd0);

        running_d = running_q;
        nr_d      = nr_q;
        state_d   = state_q;
        if (cmd_run) begin
            running_d = 1'b1;
            nr_d      = cmd_nr_in;
            state_d   = 4'd0;
        end else if (cmd_state_set && running_q) begin
            state_d = cmd_state_in;
        end else if (cmd_finish) begin
            running_d = 1'b0;
            state_d   = 4'd0;
        end
    end

    always_ff @(posedge osc_b or negedge rst_n) begin
        if (!rst_n) begin
            latch_q    <= 8'd0;
            pend_q     <= 8'd0;
            pend_vld_q <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_data_q  <= 8'd0;
            rd_stb_q   <= 1'b0;
            data_o_q   <= 8'd0;
            count_q    <= 16'd0;
            idle_q     <= 1'b0;
            running_q  <= 1'b0;
            nr_q       <= 4'd0;
            state_q    <= 4'd0;
        end else begin
            latch_q    <= latch_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            wr_stb_q   <= wr_stb_d;
            wr_data_q  <= wr_data_d;
            rd_stb_q   <= rd_stb_d;
            data_o_q   <= data_o_d;
            count_q    <= count_d;
            idle_q     <= idle_d;
            running_q  <= running_d;
            nr_q       <= nr_d;
            state_q    <= state_d;
        end
    end

    // Driver enable follows the raw pin so the bus is released immediately.
    assign data_oe     = ~read_b & latch_q[ADDR_OK_BIT];
    assign data_o      = data_o_q;
    assign wr_stb      = wr_stb_q;
    assign wr_addr     = latch_q;
    assign wr_data     = wr_data_q;
    assign rd_stb      = rd_stb_q;
    assign delay_idle  = idle_q;
    assign cmd_running = running_q;
    assign cmd_nr      = nr_q;
    assign cmd_state   = state_q;

    logic unused_edges;
    assign unused_edges = ale_rise ^ wr_fall ^ rd_rise;

endmodule
`default_nettype wire

// File: tb/tb_ibufg_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibufg_bus_if
// Description : Directed self-checking bench for the ibufg_bus_if front end.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibufg_bus_if;

    logic        osc = 1'b0;
    logic        rst_n = 1'b0;
    logic        ale = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b1;
    logic [7:0]  data_i = 8'h00;
    logic [7:0]  data_o;
    logic        data_oe;
    logic        wr_stb;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        rd_stb;
    logic [7:0]  usr_rd_data = 8'h00;
    logic        udelay_load = 1'b0;
    logic [11:0] udelay_us = 12'd0;
    logic        delay_idle;
    logic        cmd_run = 1'b0;
    logic [3:0]  cmd_nr_in = 4'd0;
    logic        cmd_finish = 1'b0;
    logic        cmd_state_set = 1'b0;
    logic [3:0]  cmd_state_in = 4'd0;
    logic        cmd_running;
    logic [3:0]  cmd_nr;
    logic [3:0]  cmd_state;

    int n_checks = 0;
    int n_fail   = 0;

    ibufg_bus_if #(
        .ID_MAJOR(16'hBEEF),
        .ID_MINOR(8'h07),
        .ADDR_OK_BIT(4),
        .CLKS_PER_US(24)
    ) dut (
        .osc(osc), .rst_n(rst_n), .ale(ale), .write(write), .read(read),
        .data_i(data_i), .data_o(data_o), .data_oe(data_oe),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .rd_stb(rd_stb),
        .usr_rd_data(usr_rd_data), .udelay_load(udelay_load), .udelay_us(udelay_us),
        .delay_idle(delay_idle), .cmd_run(cmd_run), .cmd_nr_in(cmd_nr_in),
        .cmd_finish(cmd_finish), .cmd_state_set(cmd_state_set),
        .cmd_state_in(cmd_state_in), .cmd_running(cmd_running),
        .cmd_nr(cmd_nr), .cmd_state(cmd_state)
    );

    always #5 osc = ~osc;

    function automatic logic [36:0] all_outs();
        return {data_o, data_oe, wr_stb, wr_addr, wr_data, rd_stb,
                delay_idle, cmd_running, cmd_nr, cmd_state};
    endfunction

    task automatic bus_addr(input logic [7:0] a);
        data_i = a;
        ale = 1'b1;
        repeat (3) @(negedge osc);
        ale = 1'b0;
        repeat (3) @(negedge osc);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (all_outs() !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        repeat (2) @(negedge osc);
        rst_n = 1'b1;
        @(negedge osc);
        n_checks++;
        if (delay_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle: got %b expected 1", delay_idle);
        end
    endtask

    task automatic test_addr();
        data_i = 8'h12;
        ale = 1'b1;
        repeat (3) @(negedge osc);
        ale = 1'b0;
        repeat (2) @(negedge osc);
        n_checks++;
        if (wr_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL addr_early: got %h expected 00", wr_addr);
        end
        @(negedge osc);
        n_checks++;
        if (wr_addr !== 8'h12) begin
            n_fail++;
            $display("FAIL addr_latch: got %h expected 12", wr_addr);
        end
        read = 1'b0;
        #1;
        n_checks++;
        if (data_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL oe_on: got %b expected 1", data_oe);
        end
        repeat (5) @(negedge osc);
        read = 1'b1;
        #1;
        n_checks++;
        if (data_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL oe_release: got %b expected 0", data_oe);
        end
        repeat (4) @(negedge osc);
        bus_addr(8'h02);
        read = 1'b0;
        #1;
        n_checks++;
        if (data_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL oe_addr02: got %b expected 0", data_oe);
        end
        repeat (5) @(negedge osc);
        read = 1'b1;
        repeat (4) @(negedge osc);
    endtask

    task automatic test_write();
        int pulses = 0;
        int pcyc = 0;
        logic [7:0] seen_data = 8'h00;
        logic [7:0] seen_addr = 8'h00;
        bus_addr(8'h12);
        data_i = 8'hA5;
        write = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge osc);
            if (wr_stb === 1'b1) begin
                pulses++;
                pcyc = i;
                seen_data = wr_data;
                seen_addr = wr_addr;
            end
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL wr_pulse_count: got %0d expected 1", pulses);
        end
        n_checks++;
        if (pcyc !== 3) begin
            n_fail++;
            $display("FAIL wr_latency: got %0d expected 3", pcyc);
        end
        n_checks++;
        if (seen_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL wr_data: got %h expected a5", seen_data);
        end
        n_checks++;
        if (seen_addr !== 8'h12) begin
            n_fail++;
            $display("FAIL wr_addr: got %h expected 12", seen_addr);
        end
        write = 1'b0;
        repeat (4) @(negedge osc);
    endtask

    task automatic test_read();
        logic [7:0] addrs [4] = '{8'hFD, 8'hFE, 8'hFF, 8'h13};
        logic [7:0] usrs  [4] = '{8'h55, 8'h55, 8'h55, 8'h3C};
        logic [7:0] exps  [4] = '{8'hEF, 8'hBE, 8'h07, 8'h3C};
        for (int k = 0; k < 4; k++) begin
            bus_addr(addrs[k]);
            usr_rd_data = usrs[k];
            read = 1'b0;
            repeat (3) @(negedge osc);
            n_checks++;
            if (rd_stb !== 1'b1) begin
                n_fail++;
                $display("FAIL rd_stb_%h: got %b expected 1", addrs[k], rd_stb);
            end
            @(negedge osc);
            n_checks++;
            if (data_o !== exps[k]) begin
                n_fail++;
                $display("FAIL rd_data_%h: got %h expected %h", addrs[k], data_o, exps[k]);
            end
            n_checks++;
            if (rd_stb !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_stb_end_%h: got %b expected 0", addrs[k], rd_stb);
            end
            read = 1'b1;
            repeat (4) @(negedge osc);
        end
    endtask

    task automatic test_delay();
        int lowcnt;
        udelay_us = 12'd1;
        udelay_load = 1'b1;
        @(negedge osc);
        udelay_load = 1'b0;
        lowcnt = 0;
        while (delay_idle === 1'b0 && lowcnt < 100) begin
            lowcnt++;
            @(negedge osc);
        end
        n_checks++;
        if (lowcnt !== 23) begin
            n_fail++;
            $display("FAIL delay_1us: got %0d busy cycles expected 23", lowcnt);
        end

        udelay_us = 12'd4000;
        udelay_load = 1'b1;
        @(negedge osc);
        udelay_load = 1'b0;
        lowcnt = 0;
        while (delay_idle === 1'b0 && lowcnt < 70000) begin
            lowcnt++;
            @(negedge osc);
        end
        n_checks++;
        if (lowcnt !== 65519) begin
            n_fail++;
            $display("FAIL delay_clamp: got %0d busy cycles expected 65519", lowcnt);
        end

        udelay_us = 12'd1;
        udelay_load = 1'b1;
        @(negedge osc);
        udelay_load = 1'b0;
        repeat (10) @(negedge osc);
        udelay_us = 12'd2;
        udelay_load = 1'b1;
        @(negedge osc);
        udelay_load = 1'b0;
        lowcnt = 0;
        while (delay_idle === 1'b0 && lowcnt < 200) begin
            lowcnt++;
            @(negedge osc);
        end
        n_checks++;
        if (lowcnt !== 47) begin
            n_fail++;
            $display("FAIL delay_reload: got %0d busy cycles expected 47", lowcnt);
        end

        udelay_us = 12'd0;
        udelay_load = 1'b1;
        @(negedge osc);
        udelay_load = 1'b0;
        n_checks++;
        if (delay_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL delay_zero: got %b expected 1", delay_idle);
        end
    endtask

    task automatic test_cmd();
        cmd_nr_in = 4'd5;
        cmd_run = 1'b1;
        @(negedge osc);
        cmd_run = 1'b0;
        n_checks++;
        if ({cmd_running, cmd_nr, cmd_state} !== {1'b1, 4'd5, 4'd0}) begin
            n_fail++;
            $display("FAIL cmd_run: got %b/%h/%h expected 1/5/0", cmd_running, cmd_nr, cmd_state);
        end
        cmd_state_in = 4'd9;
        cmd_state_set = 1'b1;
        @(negedge osc);
        cmd_state_set = 1'b0;
        n_checks++;
        if (cmd_state !== 4'd9) begin
            n_fail++;
            $display("FAIL cmd_state_set: got %h expected 9", cmd_state);
        end
        cmd_finish = 1'b1;
        @(negedge osc);
        cmd_finish = 1'b0;
        n_checks++;
        if ({cmd_running, cmd_state} !== {1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL cmd_finish: got %b/%h expected 0/0", cmd_running, cmd_state);
        end
        cmd_state_in = 4'd6;
        cmd_state_set = 1'b1;
        @(negedge osc);
        cmd_state_set = 1'b0;
        n_checks++;
        if (cmd_state !== 4'd0) begin
            n_fail++;
            $display("FAIL cmd_state_idle: got %h expected 0", cmd_state);
        end
        cmd_nr_in = 4'd3;
        cmd_run = 1'b1;
        cmd_finish = 1'b1;
        @(negedge osc);
        cmd_run = 1'b0;
        cmd_finish = 1'b0;
        n_checks++;
        if ({cmd_running, cmd_nr} !== {1'b1, 4'd3}) begin
            n_fail++;
            $display("FAIL cmd_run_finish: got %b/%h expected 1/3", cmd_running, cmd_nr);
        end
        cmd_state_in = 4'd4;
        cmd_state_set = 1'b1;
        @(negedge osc);
        cmd_state_set = 1'b0;
        cmd_nr_in = 4'hA;
        cmd_run = 1'b1;
        @(negedge osc);
        cmd_run = 1'b0;
        n_checks++;
        if ({cmd_running, cmd_nr, cmd_state} !== {1'b1, 4'hA, 4'd0}) begin
            n_fail++;
            $display("FAIL cmd_restart: got %b/%h/%h expected 1/a/0", cmd_running, cmd_nr, cmd_state);
        end
    endtask

    task automatic test_back_to_back();
        bus_addr(8'h13);
        usr_rd_data = 8'h66;
        data_i = 8'h77;
        write = 1'b1;
        read = 1'b0;
        repeat (3) @(negedge osc);
        n_checks++;
        if ({wr_stb, rd_stb} !== 2'b11) begin
            n_fail++;
            $display("FAIL dual_strobes: got %b%b expected 11", wr_stb, rd_stb);
        end
        n_checks++;
        if (wr_data !== 8'h77) begin
            n_fail++;
            $display("FAIL dual_wr_data: got %h expected 77", wr_data);
        end
        @(negedge osc);
        n_checks++;
        if (data_o !== 8'h66) begin
            n_fail++;
            $display("FAIL dual_rd_data: got %h expected 66", data_o);
        end
        write = 1'b0;
        read = 1'b1;
        repeat (4) @(negedge osc);

        ale = 1'b1;
        repeat (3) @(negedge osc);
        data_i = 8'h34;
        ale = 1'b0;
        write = 1'b1;
        repeat (3) @(negedge osc);
        n_checks++;
        if ({wr_stb, wr_addr, wr_data} !== {1'b1, 8'h13, 8'h34}) begin
            n_fail++;
            $display("FAIL ale_wr_same: got %b/%h/%h expected 1/13/34", wr_stb, wr_addr, wr_data);
        end
        @(negedge osc);
        n_checks++;
        if (wr_addr !== 8'h34) begin
            n_fail++;
            $display("FAIL ale_wr_after: got %h expected 34", wr_addr);
        end
        write = 1'b0;
        repeat (4) @(negedge osc);
    endtask

    task automatic test_async_reset();
        udelay_us = 12'd100;
        udelay_load = 1'b1;
        cmd_nr_in = 4'd7;
        cmd_run = 1'b1;
        @(negedge osc);
        udelay_load = 1'b0;
        cmd_run = 1'b0;
        repeat (3) @(negedge osc);
        n_checks++;
        if ({cmd_running, delay_idle} !== 2'b10) begin
            n_fail++;
            $display("FAIL pre_reset: got %b%b expected 10", cmd_running, delay_idle);
        end
        @(posedge osc);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (all_outs() !== 37'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected 0", all_outs());
        end
        @(negedge osc);
        rst_n = 1'b1;
        repeat (2) @(negedge osc);
    endtask

    initial begin
        test_reset();
        test_addr();
        test_write();
        test_read();
        test_delay();
        test_cmd();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
